left_collision_predictor: RTL and testbench

Computes where the ball will meet the left paddle's x-line so the left paddle controller can pre-position. It sits directly upstream of the left paddle controller and drives that block's `i_collision_predicted`, `i_collision_predicted_y` and `i_ball_move_up` inputs. On a frame tick it snapshots the ball state while the ball travels left, then replays the trajectory one step per clock, including top and bottom wall reflections. It holds the result until the collision happens or the ball turns away.

---
 rtl/left_collision_predictor_pkg.sv | 21 ++
 rtl/predictor_step_reflect.sv | 49 ++++
 rtl/left_collision_predictor.sv | 150 +++++++++++++++
 tb/tb_left_collision_predictor.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/left_collision_predictor_pkg.sv
// Shared constants for the left-side collision predictor.
// Holds the video and paddle geometry plus the default step, target and
// timeout values. No ports.
package left_collision_predictor_pkg;

  localparam int unsigned COORD_W            = 10;
  localparam int unsigned CNT_W              = 10;

  // Display and paddle geometry
  localparam int unsigned VVIDEO_ON          = 480;
  localparam int unsigned BALL_SIZE          = 8;
  localparam int unsigned PADDLE_WIDTH       = 10;
  localparam int unsigned X_PADDLE_INIT_LEFT = 10;

  // Predictor defaults derived from the geometry
  localparam int unsigned STEP_DEF           = 1;
  localparam int unsigned Y_BOTTOM_DEF       = VVIDEO_ON - BALL_SIZE;
  localparam int unsigned X_TARGET_DEF       = X_PADDLE_INIT_LEFT + PADDLE_WIDTH;
  localparam int unsigned TIMEOUT_DEF        = 1023;

endpackage

// File: rtl/predictor_step_reflect.sv
// One vertical trajectory step with top and bottom wall reflection.
// Ports:
//   y_i, dir_i        current ball top-y and direction (1 = up)
//   step_i            per-step displacement
//   y_bottom_i        lowest legal ball top-y
//   y_o, dir_o        next ball top-y and direction
module predictor_step_reflect
  import left_collision_predictor_pkg::*;
(
  input  logic [COORD_W-1:0] y_i,
  input  logic               dir_i,
  input  logic [COORD_W-1:0] step_i,
  input  logic [COORD_W-1:0] y_bottom_i,
  output logic [COORD_W-1:0] y_o,
  output logic               dir_o
);

  localparam int unsigned WIDE_W = COORD_W + 1;

  logic [WIDE_W-1:0] y_w;
  logic [WIDE_W-1:0] s_w;
  logic [WIDE_W-1:0] b_w;

  assign y_w = WIDE_W'(y_i);
  assign s_w = WIDE_W'(step_i);
  assign b_w = WIDE_W'(y_bottom_i);

  // Wrap-around on either wall mirrors the overshoot back into range.
  always_comb begin
    y_o   = y_i;
    dir_o = dir_i;
    if (dir_i) begin
      if (y_w >= s_w) begin
        y_o = COORD_W'(y_w - s_w);
      end else begin
        y_o   = COORD_W'(s_w - y_w);
        dir_o = 1'b0;
      end
    end else begin
      if ((y_w + s_w) <= b_w) begin
        y_o = COORD_W'(y_w + s_w);
      end else begin
        y_o   = COORD_W'((b_w << 1) - y_w - s_w);
        dir_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/left_collision_predictor.sv
// Predicts the ball top-y where it reaches the left paddle x-line.
// Ports:
//   i_clock, i_reset           clock, async active-high reset
//   i_frame_tick               one-cycle pulse, ball inputs stable
//   i_ball_x, i_ball_y         ball position
//   i_ball_move_left/up        ball direction
//   i_ball_in_game             ball in play
//   i_left_paddle_collision    ball hit left paddle
//   o_collision_predicted      prediction valid
//   o_collision_predicted_y    predicted top-y at the target x
//   o_ball_move_up             predicted vertical direction on arrival
//   o_busy                     trajectory replay in progress
module left_collision_predictor
  import left_collision_predictor_pkg::*;
#(
  parameter int unsigned STEP     = STEP_DEF,
  parameter int unsigned Y_BOTTOM = Y_BOTTOM_DEF,
  parameter int unsigned X_TARGET = X_TARGET_DEF,
  parameter int unsigned TIMEOUT  = TIMEOUT_DEF
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_frame_tick,
  input  logic [COORD_W-1:0] i_ball_x,
  input  logic [COORD_W-1:0] i_ball_y,
  input  logic               i_ball_move_left,
  input  logic               i_ball_move_up,
  input  logic               i_ball_in_game,
  input  logic               i_left_paddle_collision,
  output logic               o_collision_predicted,
  output logic [COORD_W-1:0] o_collision_predicted_y,
  output logic               o_ball_move_up,
  output logic               o_busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    VALID = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [COORD_W-1:0] x_q, x_d;
  logic [COORD_W-1:0] y_q, y_d;
  logic               dir_q, dir_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               armed_q, armed_d;
  logic               pred_q, pred_d;
  logic [COORD_W-1:0] pred_y_q, pred_y_d;
  logic               pred_up_q, pred_up_d;
  logic               busy_q, busy_d;

  logic [COORD_W-1:0] y_step;
  logic               dir_step;

  predictor_step_reflect u_step (
    .y_i        (y_q),
    .dir_i      (dir_q),
    .step_i     (COORD_W'(STEP)),
    .y_bottom_i (COORD_W'(Y_BOTTOM)),
    .y_o        (y_step),
    .dir_o      (dir_step)
  );

  // State and output registers
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= IDLE;
      x_q       <= '0;
      y_q       <= '0;
      dir_q     <= 1'b0;
      cnt_q     <= '0;
      armed_q   <= 1'b1;
      pred_q    <= 1'b0;
      pred_y_q  <= '0;
      pred_up_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      dir_q     <= dir_d;
      cnt_q     <= cnt_d;
      armed_q   <= armed_d;
      pred_q    <= pred_d;
      pred_y_q  <= pred_y_d;
      pred_up_q <= pred_up_d;
      busy_q    <= busy_d;
    end
  end

  // Next-state, trajectory replay and output decode
  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    dir_d     = dir_q;
    cnt_d     = cnt_q;
    armed_d   = armed_q;
    pred_y_d  = pred_y_q;
    pred_up_d = pred_up_q;

    unique case (state_q)
      IDLE: begin
        if (i_frame_tick && i_ball_in_game && i_ball_move_left && armed_q) begin
          x_d     = i_ball_x;
          y_d     = i_ball_y;
          dir_d   = i_ball_move_up;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        if (!i_ball_in_game || !i_ball_move_left) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_W'(TIMEOUT)) begin
          state_d = IDLE;
        end else if (x_q <= COORD_W'(X_TARGET)) begin
          state_d   = VALID;
          pred_y_d  = y_q;
          pred_up_d = dir_q;
        end else begin
          x_d   = x_q - COORD_W'(STEP);
          y_d   = y_step;
          dir_d = dir_step;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      VALID: begin
        if (i_left_paddle_collision || !i_ball_in_game || !i_ball_move_left) begin
          state_d = IDLE;
          // A ball just returned by the paddle must turn away before recapture.
          if (i_left_paddle_collision) armed_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (!i_ball_move_left) armed_d = 1'b1;

    pred_d = (state_d == VALID);
    busy_d = (state_d == CALC);
  end

  assign o_collision_predicted   = pred_q;
  assign o_collision_predicted_y = pred_y_q;
  assign o_ball_move_up          = pred_up_q;
  assign o_busy                  = busy_q;

endmodule

// File: tb/tb_left_collision_predictor.sv
module tb_left_collision_predictor;

  logic       i_clock = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_frame_tick = 1'b0;
  logic [9:0] i_ball_x = '0;
  logic [9:0] i_ball_y = '0;
  logic       i_ball_move_left = 1'b0;
  logic       i_ball_move_up = 1'b0;
  logic       i_ball_in_game = 1'b0;
  logic       i_left_paddle_collision = 1'b0;
  logic       o_collision_predicted;
  logic [9:0] o_collision_predicted_y;
  logic       o_ball_move_up;
  logic       o_busy;

  left_collision_predictor dut (
    .i_clock                 (i_clock),
    .i_reset                 (i_reset),
    .i_frame_tick            (i_frame_tick),
    .i_ball_x                (i_ball_x),
    .i_ball_y                (i_ball_y),
    .i_ball_move_left        (i_ball_move_left),
    .i_ball_move_up          (i_ball_move_up),
    .i_ball_in_game          (i_ball_in_game),
    .i_left_paddle_collision (i_left_paddle_collision),
    .o_collision_predicted   (o_collision_predicted),
    .o_collision_predicted_y (o_collision_predicted_y),
    .o_ball_move_up          (o_ball_move_up),
    .o_busy                  (o_busy)
  );

  always #5 i_clock = ~i_clock;

  typedef struct {
    int y;
    int up;
    int lat;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   cap_cyc  = 0;
  logic pred_prev = 1'b0;

  always @(posedge i_clock) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Monitor: each new prediction is matched against the oldest expectation.
  always @(negedge i_clock) begin
    if (!i_reset && o_collision_predicted && !pred_prev) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_prediction", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("pred_y", int'(o_collision_predicted_y), e.y);
        chk("pred_up", int'(o_ball_move_up), e.up);
        chk("pred_latency", cyc - cap_cyc, e.lat);
      end
    end
    pred_prev = o_collision_predicted;
  end

  // Drive a one-cycle frame tick; capture happens on the edge in between.
  task automatic tick(input int x, input int y, input logic up);
    @(negedge i_clock);
    i_ball_x       = 10'(x);
    i_ball_y       = 10'(y);
    i_ball_move_up = up;
    i_frame_tick   = 1'b1;
    @(negedge i_clock);
    i_frame_tick = 1'b0;
    cap_cyc      = cyc;
  endtask

  task automatic expect_pred(input int y, input int up, input int lat);
    exp_t e;
    e.y = y; e.up = up; e.lat = lat;
    exp_q.push_back(e);
  endtask

  task automatic wait_pred(input string name, input int budget);
    int n = 0;
    while (!o_collision_predicted && n < budget) begin
      @(negedge i_clock);
      n++;
    end
    chk(name, int'(o_collision_predicted), 1);
    @(negedge i_clock);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge i_clock);
  endtask

  task automatic turn_around();
    @(negedge i_clock);
    i_ball_move_left = 1'b0;
    @(negedge i_clock);
    i_ball_move_left = 1'b1;
  endtask

  initial begin
    // Reset state
    idle(2);
    chk("rst_pred", int'(o_collision_predicted), 0);
    chk("rst_y", int'(o_collision_predicted_y), 0);
    chk("rst_up", int'(o_ball_move_up), 0);
    chk("rst_busy", int'(o_busy), 0);
    i_ball_in_game   = 1'b1;
    i_ball_move_left = 1'b1;
    // Tick in the same cycle reset is released is ignored
    i_frame_tick = 1'b1;
    i_ball_x     = 10'd100;
    i_ball_y     = 10'd200;
    @(posedge i_clock);
    #1 i_reset = 1'b0;
    @(negedge i_clock);
    i_frame_tick = 1'b0;
    idle(1);
    chk("rst_release_tick_busy", int'(o_busy), 0);

    // 1: straight path, down
    tick(100, 200, 1'b0);
    expect_pred(280, 0, 81);
    chk("s1_busy", int'(o_busy), 1);
    wait_pred("s1_wait", 200);
    // Tick in VALID is ignored
    tick(50, 10, 1'b1);
    chk("s1_valid_tick_pred", int'(o_collision_predicted), 1);
    chk("s1_valid_tick_y", int'(o_collision_predicted_y), 280);

    // 5: collision release, no recapture while still moving left
    i_left_paddle_collision = 1'b1;
    @(negedge i_clock);
    i_left_paddle_collision = 1'b0;
    chk("s5_pred_fall", int'(o_collision_predicted), 0);
    chk("s5_y_hold", int'(o_collision_predicted_y), 280);
    for (int i = 0; i < 3; i++) begin
      tick(100, 200, 1'b0);
      chk("s5_no_recapture", int'(o_busy), 0);
    end
    turn_around();

    // 2: top reflection
    tick(100, 30, 1'b1);
    expect_pred(50, 0, 81);
    chk("s2_busy", int'(o_busy), 1);
    wait_pred("s2_wait", 200);
    @(negedge i_clock);
    i_ball_move_left = 1'b0;
    @(negedge i_clock);
    chk("s2_release_pred", int'(o_collision_predicted), 0);
    i_ball_move_left = 1'b1;

    // 3: bottom reflection, released by collision coinciding with a tick
    tick(60, 460, 1'b0);
    expect_pred(444, 1, 41);
    wait_pred("s3_wait", 100);
    @(negedge i_clock);
    i_left_paddle_collision = 1'b1;
    i_frame_tick            = 1'b1;
    @(negedge i_clock);
    i_left_paddle_collision = 1'b0;
    i_frame_tick            = 1'b0;
    chk("s3_coll_tick_pred", int'(o_collision_predicted), 0);
    idle(1);
    chk("s3_coll_tick_busy", int'(o_busy), 0);
    turn_around();

    // Already at the target: one-edge latency
    tick(15, 100, 1'b1);
    expect_pred(100, 1, 1);
    wait_pred("s_near_wait", 10);
    turn_around();

    // 4: direction flips during CALC
    tick(100, 200, 1'b0);
    idle(5);
    i_ball_move_left = 1'b0;
    @(negedge i_clock);
    chk("s4_busy_fall", int'(o_busy), 0);
    chk("s4_pred", int'(o_collision_predicted), 0);
    i_ball_move_left = 1'b1;
    idle(100);
    chk("s4_pred_late", int'(o_collision_predicted), 0);

    // 6: async reset during CALC
    tick(100, 200, 1'b0);
    idle(9);
    chk("s6_busy_before", int'(o_busy), 1);
    #2 i_reset = 1'b1;
    #1;
    chk("s6_rst_busy", int'(o_busy), 0);
    chk("s6_rst_pred", int'(o_collision_predicted), 0);
    chk("s6_rst_y", int'(o_collision_predicted_y), 0);
    chk("s6_rst_up", int'(o_ball_move_up), 0);
    idle(2);
    i_reset = 1'b0;
    idle(1);
    tick(100, 200, 1'b0);
    expect_pred(280, 0, 81);
    chk("s6_restart_busy", int'(o_busy), 1);
    wait_pred("s6_wait", 200);

    idle(2);
    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
